// File: rtl/muldiv_sequencer.sv
// Sequential MIPS-style HI/LO multiply/divide unit: 32-cycle shift-add multiply and restoring divide.
// Optional build macro MULDIV_FAST_MULT_EN: single-cycle combinational multiply (IDLE->FIN).
module muldiv_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t      state, state_nxt;
    logic [63:0] work;     // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
    logic [31:0] opnd;     // multiplicand or divisor magnitude
    logic [4:0]  cnt;
    logic        is_div, neg_lo, neg_hi, dz;

    logic        accept, commit, is_signed, sa, sb;
    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_sh;
    logic [33:0] div_diff;
    logic [63:0] prod;
    logic [31:0] res_hi, res_lo;

    assign busy      = (state != IDLE);
    assign accept    = (state == IDLE) && start && !cancel;
    assign commit    = (state == FIN) && !cancel;
    assign is_signed = (op == 3'd0) || (op == 3'd2);
    assign sa        = is_signed & a[31];
    assign sb        = is_signed & b[31];
    assign mag_a     = sa ? -a : a;
    assign mag_b     = sb ? -b : b;

    assign mul_sum  = {1'b0, work[63:32]} + (work[0] ? {1'b0, opnd} : 33'd0);
    assign div_sh   = {work[63:32], work[31]};
    assign div_diff = {1'b0, div_sh} - {2'b00, opnd};

    // Sign fix-up; a zero divisor forces an all-ones quotient while the remainder is |a| re-signed to a.
    always_comb begin
        prod   = neg_lo ? -work : work;
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div) begin
            res_hi = neg_hi ? -work[63:32] : work[63:32];
            res_lo = dz ? 32'hFFFF_FFFF : (neg_lo ? -work[31:0] : work[31:0]);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (op)
`ifdef MULDIV_FAST_MULT_EN
                        3'd0, 3'd1: state_nxt = FIN;
`else
                        3'd0, 3'd1: state_nxt = MUL;
`endif
                        3'd2, 3'd3: state_nxt = DIV;
                        default:    state_nxt = IDLE;
                    endcase
                end
            end
            MUL, DIV: begin
                if (cancel)           state_nxt = IDLE;
                else if (cnt == 5'd31) state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work        <= '0;
            opnd        <= '0;
            cnt         <= '0;
            is_div      <= 1'b0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            dz          <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= commit;
            div_by_zero <= commit & is_div & dz;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            3'd0, 3'd1: begin
                                opnd   <= mag_a;
`ifdef MULDIV_FAST_MULT_EN
                                work   <= {32'd0, mag_a} * {32'd0, mag_b};
`else
                                work   <= {32'd0, mag_b};
`endif
                                is_div <= 1'b0;
                                neg_lo <= sa ^ sb;
                                neg_hi <= 1'b0;
                                dz     <= 1'b0;
                                cnt    <= '0;
                            end
                            3'd2, 3'd3: begin
                                opnd   <= mag_b;
                                work   <= {32'd0, mag_a};
                                is_div <= 1'b1;
                                neg_lo <= sa ^ sb;
                                neg_hi <= sa;
                                dz     <= (b == 32'd0);
                                cnt    <= '0;
                            end
                            3'd4:    hi <= a;
                            3'd5:    lo <= a;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    work <= {mul_sum, work[31:1]};
                    cnt  <= cnt + 5'd1;
                end
                DIV: begin
                    if (!div_diff[33]) work <= {div_diff[31:0], work[30:0], 1'b1};
                    else               work <= {div_sh[31:0], work[30:0], 1'b0};
                    cnt <= cnt + 5'd1;
                end
                FIN: begin
                    if (commit) begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed checks of muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0, b = '0;
    logic        cancel = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] mhi = '0, mlo = '0;

`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    muldiv_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int          ix, iy;
        longint      lx, ly;
        logic [63:0] p;
        ix = x; iy = y;
        case (o)
            3'd0: begin lx = ix; ly = iy; p = lx * ly; return p; end
            3'd1: begin p = {32'd0, x} * {32'd0, y}; return p; end
            3'd2: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(ix % iy), 32'(ix / iy)};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Issue one op; optional extra start while busy and optional cancel, both counted in cycles after acceptance.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int extra_at, input int cancel_at);
        logic [63:0] exp;
        int  edges, lat;
        bit  cancelled;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        if (o <= 3'd3) begin
            chk("busy_after_accept", busy, 1);
            exp = ref_model(o, x, y);
            lat = (o <= 3'd1) ? MUL_LAT : DIV_LAT;
            edges = 0; cancelled = 0;
            while (!done && edges < 100) begin
                if (edges == extra_at) begin start = 1'b1; op = 3'd4; end
                if (edges == cancel_at) cancel = 1'b1;
                @(negedge clk);
                edges++;
                start = 1'b0;
                if (cancel) begin cancel = 1'b0; cancelled = 1; break; end
            end
            if (cancelled) begin
                chk("cancel_busy", busy, 0);
                chk("cancel_done", done, 0);
                chk("cancel_hilo", {hi, lo}, {mhi, mlo});
            end else begin
                chk("latency", edges + 1, lat);
                chk("result", {hi, lo}, exp);
                chk("dz", div_by_zero, (o >= 3'd2 && y == 0));
                chk("busy_at_done", busy, 0);
                {mhi, mlo} = exp;
                @(negedge clk);
                chk("done_pulse", {done, div_by_zero}, 0);
            end
        end else begin
            if (o == 3'd4) mhi = x;
            if (o == 3'd5) mlo = x;
            chk("mt_hilo", {hi, lo}, {mhi, mlo});
            chk("mt_busy_done", {busy, done}, 0);
        end
    endtask

    initial begin
        #1;
        chk("rst_hilo", {hi, lo}, 0);
        chk("rst_flags", {busy, done, div_by_zero}, 0);
        #20 rst_n = 1'b1;

        do_op(3'd0, 32'hFFFF_FFFD, 32'd7, -1, -1);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, -1, -1);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        do_op(3'd3, 32'd7, 32'd0, -1, -1);
        do_op(3'd2, 32'hFFFF_FFF0, 32'd0, -1, -1);
        do_op(3'd6, 32'hDEAD_BEEF, 32'd1, -1, -1);
        do_op(3'd7, 32'hDEAD_BEEF, 32'd1, -1, -1);

        // Cancelled divide, then immediate restart
        do_op(3'd4, 32'h1234, 32'd0, -1, -1);
        do_op(3'd3, 32'd100, 32'd7, -1, 10);
        chk("cancel_no_done", done, 0);
        do_op(3'd3, 32'd100, 32'd7, -1, -1);

        // Start with cancel in IDLE is dropped
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = 3'd4; a = 32'hCAFE_0000;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("idle_cancel", {busy, hi}, {1'b0, mhi});

        // Start while busy is ignored
        do_op(3'd2, 32'h7654_3210, 32'hFFFF_FF03, 5, -1);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  o;
            logic [31:0] x, y;
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 0;
                1: y = 32'hFFFF_FFFF;
                2: x = 32'h8000_0000;
                3: y = 32'($urandom_range(1, 20));
                default: ;
            endcase
            do_op(o, x, y, -1, -1);
        end

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd12345; b = 32'd17;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_hilo", {hi, lo}, 0);
        chk("mid_rst_flags", {busy, done, div_by_zero}, 0);
        mhi = '0; mlo = '0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        do_op(3'd3, 32'd1000, 32'd33, -1, -1);
        do_op(3'd0, 32'h8000_0000, 32'h8000_0000, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=%0d exp=%0d", n_tests, -1);
        $fatal(1, "timeout");
    end
endmodule
